// File: rtl/logicnet_layer_sequencer_if.sv
// Input/output stream handshake bundle for the layer sequencer.
// master = upstream/downstream side, slave = the sequencer.
interface logicnet_layer_sequencer_if #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/logicnet_layer_sequencer.sv
// Time-multiplexes one shared neuron LUT across all neurons of a layer:
// capture input vector, issue one neuron index per cycle, collect results into slots.
module logicnet_layer_sequencer #(
  parameter int unsigned IN_W        = 64,
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned OUT_BW      = 2,
  parameter int unsigned LUT_LAT     = 1,
  parameter int unsigned IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  logicnet_layer_sequencer_if.slave bus,
  output logic [IN_W-1:0]          lut_vec,
  output logic [IDX_W-1:0]         lut_idx,
  output logic                     lut_req,
  input  logic [OUT_BW-1:0]        lut_out,
  output logic                     busy,
  output logic [15:0]              vec_count
);
  localparam int unsigned      OUT_W    = NUM_NEURONS * OUT_BW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_vec_q;
  logic [15:0]      vec_cnt_q;
  logic             ret_v;
  logic [IDX_W-1:0] ret_idx;
  logic             accept, deliver, last_issue;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign deliver    = (state_q == HOLD) && bus.out_ready;
  assign last_issue = (lut_idx == LAST_IDX);

  // Tag pipeline: (valid, idx) follows each issue so the returning result lands in its slot.
  if (LUT_LAT == 0) begin : g_comb
    assign ret_v   = lut_req;
    assign ret_idx = lut_idx;
  end else begin : g_pipe
    logic [LUT_LAT-1:0] tag_v;
    logic [IDX_W-1:0]   tag_idx [LUT_LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_v <= '0;
        for (int unsigned i = 0; i < LUT_LAT; i++) tag_idx[i] <= '0;
      end else if (flush) begin
        tag_v <= '0;
      end else begin
        tag_v[0]   <= lut_req;
        tag_idx[0] <= lut_idx;
        for (int unsigned i = 1; i < LUT_LAT; i++) begin
          tag_v[i]   <= tag_v[i-1];
          tag_idx[i] <= tag_idx[i-1];
        end
      end
    end

    assign ret_v   = tag_v[LUT_LAT-1];
    assign ret_idx = tag_idx[LUT_LAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ISSUE;
      ISSUE:   if (last_issue) state_d = (LUT_LAT > 0) ? DRAIN : HOLD;
      DRAIN:   if (ret_v && (ret_idx == LAST_IDX)) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    lut_req       = (state_q == ISSUE);
    bus.out_valid = (state_q == HOLD);
    busy          = (state_q != IDLE);
  end

  // flush discards any result still in flight; unwritten slots keep the previous vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_vec   <= '0;
      lut_idx   <= '0;
      out_vec_q <= '0;
      vec_cnt_q <= '0;
    end else if (!flush) begin
      if (accept) begin
        lut_vec <= bus.in_vec;
        lut_idx <= '0;
      end else if (lut_req && !last_issue) begin
        lut_idx <= lut_idx + 1'b1;
      end
      if (deliver) vec_cnt_q <= vec_cnt_q + 1'b1;
      for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
        if (ret_v && (ret_idx == IDX_W'(k))) out_vec_q[k*OUT_BW +: OUT_BW] <= lut_out;
      end
    end
  end

  assign bus.out_vec = out_vec_q;
  assign vec_count   = vec_cnt_q;
endmodule

// File: tb/tb_logicnet_layer_sequencer.sv
// Directed bench: three sequencer builds (LUT_LAT 1, 0, 3) fed the same stimulus,
// each with a LUT model of matching latency.
module tb_logicnet_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_vec = '0;
  logic [1:0]  mode = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logicnet_layer_sequencer_if #(.IN_W(64), .OUT_W(32)) bus0 ();
  logicnet_layer_sequencer_if #(.IN_W(64), .OUT_W(32)) bus1 ();
  logicnet_layer_sequencer_if #(.IN_W(64), .OUT_W(32)) bus2 ();

  assign bus0.in_valid = in_valid;  assign bus0.in_vec = in_vec;  assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid;  assign bus1.in_vec = in_vec;  assign bus1.out_ready = out_ready;
  assign bus2.in_valid = in_valid;  assign bus2.in_vec = in_vec;  assign bus2.out_ready = out_ready;

  logic        ovld [3];
  logic        irdy [3];
  logic [31:0] ovec [3];
  assign ovld[0] = bus0.out_valid;  assign irdy[0] = bus0.in_ready;  assign ovec[0] = bus0.out_vec;
  assign ovld[1] = bus1.out_valid;  assign irdy[1] = bus1.in_ready;  assign ovec[1] = bus1.out_vec;
  assign ovld[2] = bus2.out_valid;  assign irdy[2] = bus2.in_ready;  assign ovec[2] = bus2.out_vec;

  logic [63:0] lvec [3];
  logic [3:0]  lidx [3];
  logic        lreq [3];
  logic        busy_a [3];
  logic [15:0] vcnt [3];
  logic [1:0]  lout0, lout1, lout2;

  logicnet_layer_sequencer #(.IN_W(64), .NUM_NEURONS(16), .OUT_BW(2), .LUT_LAT(1), .IDX_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .lut_vec(lvec[0]), .lut_idx(lidx[0]),
    .lut_req(lreq[0]), .lut_out(lout0), .busy(busy_a[0]), .vec_count(vcnt[0]));
  logicnet_layer_sequencer #(.IN_W(64), .NUM_NEURONS(16), .OUT_BW(2), .LUT_LAT(0), .IDX_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .lut_vec(lvec[1]), .lut_idx(lidx[1]),
    .lut_req(lreq[1]), .lut_out(lout1), .busy(busy_a[1]), .vec_count(vcnt[1]));
  logicnet_layer_sequencer #(.IN_W(64), .NUM_NEURONS(16), .OUT_BW(2), .LUT_LAT(3), .IDX_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .lut_vec(lvec[2]), .lut_idx(lidx[2]),
    .lut_req(lreq[2]), .lut_out(lout2), .busy(busy_a[2]), .vec_count(vcnt[2]));

  // LUT contents selectable per test so slot placement and lut_vec use are both visible.
  function automatic logic [1:0] lut_f(input logic [1:0] m, input logic [63:0] v, input logic [3:0] idx);
    case (m)
      2'd0:    return idx[1:0];
      2'd1:    return ~idx[1:0];
      2'd2:    return v[{idx, 2'b00} +: 2];
      default: return idx[3:2];
    endcase
  endfunction

  logic [1:0] p1, p3a, p3b, p3c;
  always @(posedge clk) begin
    p1  <= lut_f(mode, lvec[0], lidx[0]);
    p3a <= lut_f(mode, lvec[2], lidx[2]);
    p3b <= p3a;
    p3c <= p3b;
  end
  assign lout0 = p1;
  assign lout1 = lut_f(mode, lvec[1], lidx[1]);
  assign lout2 = p3c;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] vec;
    logic [31:0] exp;
  } rec_t;
  rec_t tbl [4];

  int          exp_lat [3] = '{18, 17, 20};
  int          got_lat [3];
  logic [31:0] got_ov  [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_a[0] || busy_a[1] || busy_a[2]) && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 64'(busy_a[0] || busy_a[1] || busy_a[2]), 64'd0);
  endtask

  task automatic send(input logic [1:0] m, input logic [63:0] v);
    wait_idle();
    @(negedge clk);
    mode = m; in_vec = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [1:0] m, input logic [63:0] v);
    out_ready = 1'b1;
    send(m, v);
    for (int d = 0; d < 3; d++) begin got_lat[d] = 0; got_ov[d] = '0; end
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
        if (ovld[d] && got_lat[d] == 0) begin got_lat[d] = c + 1; got_ov[d] = ovec[d]; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, rises, prev;
    int t [3];

    tbl[0] = '{2'd0, 64'h0123_4567_89AB_CDEF, 32'hE4E4_E4E4};
    tbl[1] = '{2'd2, 64'hFFFF_0000_AAAA_5555, 32'hFF00_AA55};
    tbl[2] = '{2'd1, 64'h0000_0000_0000_0000, 32'h1B1B_1B1B};
    tbl[3] = '{2'd3, 64'h0000_0000_0000_0000, 32'hFFAA_5500};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready",  64'(irdy[0]), 64'd1);
    chk("rst_out_valid", 64'(ovld[0]), 64'd0);
    chk("rst_lut_req",   64'(lreq[0]), 64'd0);
    chk("rst_busy",      64'(busy_a[0]), 64'd0);
    chk("rst_vec_count", 64'(vcnt[0]), 64'd0);
    chk("rst_lut_vec",   lvec[0], 64'd0);
    chk("rst_lut_idx",   64'(lidx[0]), 64'd0);
    chk("rst_out_vec",   64'(ovec[0]), 64'd0);

    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i].mode, tbl[i].vec);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("tbl%0d_dut%0d_latency", i, d), 64'(got_lat[d]), 64'(exp_lat[d]));
        chk($sformatf("tbl%0d_dut%0d_out_vec", i, d), 64'(got_ov[d]), 64'(tbl[i].exp));
        chk($sformatf("tbl%0d_dut%0d_vec_count", i, d), 64'(vcnt[d]), 64'(i + 1));
      end
    end

    // Output held off by downstream for 10 cycles.
    out_ready = 1'b0;
    send(2'd0, 64'h0123_4567_89AB_CDEF);
    n = 0;
    while (!ovld[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("hold_reached", 64'(ovld[0]), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk("hold_out_valid", 64'(ovld[0]), 64'd1);
      chk("hold_out_vec",   64'(ovec[0]), 64'hE4E4_E4E4);
      chk("hold_in_ready",  64'(irdy[0]), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("hold_accept_valid", 64'(ovld[0]), 64'd1);
    @(posedge clk); #1;
    chk("hold_after_in_ready",  64'(irdy[0]), 64'd1);
    chk("hold_after_out_valid", 64'(ovld[0]), 64'd0);
    chk("hold_vec_count",       64'(vcnt[0]), 64'd5);

    // flush during issue of neuron 7.
    send(2'd3, 64'h0);
    n = 0;
    while (!(lreq[0] && lidx[0] == 4'd7) && n < 40) begin @(posedge clk); #1; n++; end
    chk("flush_at_idx7", 64'(lidx[0]), 64'd7);
    chk("issue_in_ready", 64'(irdy[0]), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy",      64'(busy_a[0]), 64'd0);
    chk("flush_in_ready",  64'(irdy[0]), 64'd1);
    chk("flush_out_valid", 64'(ovld[0]), 64'd0);
    chk("flush_vec_count", 64'(vcnt[0]), 64'd5);
    cnt = 0;
    repeat (25) begin @(posedge clk); #1; if (ovld[0]) cnt++; end
    chk("flush_no_out_valid", 64'(cnt), 64'd0);
    run_vec(2'd2, 64'hFFFF_0000_AAAA_5555);
    chk("post_flush_latency",   64'(got_lat[0]), 64'd18);
    chk("post_flush_out_vec",   64'(got_ov[0]), 64'hFF00_AA55);
    chk("post_flush_vec_count", 64'(vcnt[0]), 64'd6);

    // Asynchronous reset while draining.
    send(2'd0, 64'h0123_4567_89AB_CDEF);
    n = 0;
    while (!(busy_a[0] && !lreq[0] && !ovld[0]) && n < 40) begin @(posedge clk); #1; n++; end
    chk("drain_reached", 64'(busy_a[0] && !lreq[0] && !ovld[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_lut_vec",   lvec[0], 64'd0);
    chk("arst_out_vec",   64'(ovec[0]), 64'd0);
    chk("arst_lut_idx",   64'(lidx[0]), 64'd0);
    chk("arst_lut_req",   64'(lreq[0]), 64'd0);
    chk("arst_out_valid", 64'(ovld[0]), 64'd0);
    chk("arst_busy",      64'(busy_a[0]), 64'd0);
    chk("arst_vec_count", 64'(vcnt[0]), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_release_in_ready", 64'(irdy[0]), 64'd1);

    // Back-to-back vectors with in_valid held high.
    wait_idle();
    @(negedge clk);
    mode = 2'd2; in_vec = 64'hFFFF_0000_AAAA_5555; out_ready = 1'b1; in_valid = 1'b1;
    prev = 0; rises = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (ovld[0] && prev == 0) begin
        t[rises] = c;
        chk("b2b_out_vec", 64'(ovec[0]), 64'hFF00_AA55);
        rises++;
        if (rises == 3) in_valid = 1'b0;
      end
      prev = ovld[0] ? 1 : 0;
      if (rises == 3) break;
    end
    @(posedge clk); #1;
    chk("b2b_pulses",    64'(rises), 64'd3);
    chk("b2b_gap1",      64'(t[1] - t[0]), 64'd19);
    chk("b2b_gap2",      64'(t[2] - t[1]), 64'd19);
    chk("b2b_vec_count", 64'(vcnt[0]), 64'd3);

    // vec_count wrap from 0xFFFF.
    wait_idle();
    @(negedge clk);
    force dut0.vec_cnt_q = 16'hFFFF;
    #1;
    release dut0.vec_cnt_q;
    #1;
    chk("preload_vec_count", 64'(vcnt[0]), 64'hFFFF);
    run_vec(2'd1, 64'h0);
    chk("wrap_latency",   64'(got_lat[0]), 64'd18);
    chk("wrap_out_vec",   64'(got_ov[0]), 64'h1B1B_1B1B);
    chk("wrap_vec_count", 64'(vcnt[0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
